adder4b_resp_checker: RTL and testbench
=======================================

Name: adder4b_resp_checker

Overview:
- Synthesizable response checker: the receiving end of the adder stimulus/response interface.
- Takes each stimulus vector (a, b, c_in) and the DUT's sum/carry response, computes the golden result, and counts matches and mismatches.
- Sits beside the 4-bit adder in self-checking benches and on-board BIST wrappers; reports done/pass after a programmed number of vectors.

Parameters:
- WIDTH, 4, operand width in bits.
- CNT_W, 8, width of the vector-target, vector-count and error-count registers.
- LAT, 0, DUT response latency in cycles after its stimulus (legal 0..3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a check run.
- num_vec  in  CNT_W  vectors in the run; sampled on the start cycle.
- stim_valid  in  1  stim_a/stim_b/stim_cin valid this cycle.
- stim_a  in  WIDTH  operand A.
- stim_b  in  WIDTH  operand B.
- stim_cin  in  1  carry in.
- dut_s  in  WIDTH  DUT sum, valid LAT cycles after its stimulus.
- dut_cout  in  1  DUT carry out.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_cnt==0.
- vec_cnt  out  CNT_W  vectors compared this run.
- err_cnt  out  CNT_W  mismatches this run; saturates at all-ones.
- first_fail_idx  out  CNT_W  index of first mismatching vector (optional feature).
- first_fail_exp  out  WIDTH+1  expected {cout,s} of first mismatch (optional feature).

Behaviour:
- Reset, asynchronous and active-low: FSM=IDLE. busy, done and pass are 0. vec_cnt, err_cnt, the issued counter, the delay-line valid bits and the first_fail_* outputs are all 0.
- FSM IDLE -> RUN on start:
  - Clears vec_cnt, err_cnt, the issued counter, the delay line and the first-fail capture.
  - Latches num_vec.
  - If num_vec==0, goes IDLE -> DONE instead.
- Stimulus acceptance: in RUN, stim_valid is accepted while issued < num_vec. Each accepted vector increments issued. Vectors beyond num_vec, and any stim_valid in IDLE or DONE, are ignored.
- Expected value: exp = a + b + cin, computed at WIDTH+1 bits with no truncation. Example: F+F+1 = 0x1F.
- Alignment:
  - Accepted {valid, exp} enters a LAT-stage shift line.
  - With LAT=0, the compare happens in the same cycle against dut_s/dut_cout.
  - With LAT=N, the compare happens on the cycle the tagged entry exits stage N.
- Compare, on each tagged-valid cycle:
  - vec_cnt increments.
  - If {dut_cout,dut_s} != exp, err_cnt increments, saturating at all-ones.
- RUN -> DONE on the clock edge after the compare that makes vec_cnt == num_vec. The final vector's result is included.
- In DONE: done=1 and pass=(err_cnt==0). Counts hold.
  - start in DONE begins a new run with the same rules as from IDLE.
  - start in RUN is ignored.
- Simultaneous accept and compare in one cycle is normal operation; both take effect.
- rst_n asserted mid-run: immediate return to reset state. Pending delay-line entries are discarded.

Optional Feature:
- Macro: ADDER4B_CHK_FIRST_FAIL_EN.
- Defined:
  - On the first mismatch of a run, first_fail_idx captures the 0-based compare index and first_fail_exp captures exp.
  - Both hold until the next start or reset. Later mismatches do not overwrite them.
- Undefined: first_fail_idx and first_fail_exp are tied to 0, and no capture registers are built.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, first_fail_*=0.
- Good run, LAT=0, num_vec=5: vectors (0,0,0), (F,0,0), (0,F,1), (F,1,0), (1,F,0) with a correct DUT.
  - DUT responses 0x00, 0x0F, 0x10, 0x10, 0x10.
  - done=1 one cycle after the 5th compare; pass=1, vec_cnt=5, err_cnt=0.
- Fault injection, LAT=0, same 5 vectors: force dut_s=0xE on the vector (F,0,0).
  - err_cnt=1, pass=0.
  - With the macro: first_fail_idx=1, first_fail_exp=0x0F.
- Latency, LAT=2, num_vec=4: stim_valid with 1-cycle gaps and a DUT model delayed 2 cycles.
  - Operands include F+F+1 -> expected 0x1F.
  - pass=1, vec_cnt=4. Also apply 2 extra stim_valid after the 4th -> ignored, vec_cnt stays 4.
- Zero target: start with num_vec=0 -> done=1 and pass=1 on the next cycle; busy never asserts.
- Reset mid-run: num_vec=5; assert rst_n=0 after 3 compares -> all outputs 0 immediately, FSM=IDLE. A new start then gives a clean 5-vector run with pass=1.

Source files
------------

// File: rtl/adder4b_resp_checker.sv
// -----------------------------------------------------------------------------
// adder4b_resp_checker
//
// Response checker for a WIDTH-bit adder. It takes each stimulus vector
// (stim_a, stim_b, stim_cin), computes the golden {cout,sum}, and delays it
// LAT cycles to line up with the DUT response. It then counts compared vectors
// and mismatches. After num_vec compares it reports done/pass.
//
// Optional feature (compile-time macro ADDER4B_CHK_FIRST_FAIL_EN):
//   when defined, the index and the expected value of the first mismatch of a
//   run are captured. When undefined, first_fail_* are tied to zero.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle pulse, begins a run (ignored while busy)
//   num_vec        vectors in the run, sampled with start
//   stim_valid     stimulus vector valid this cycle
//   stim_a/stim_b  operands
//   stim_cin       carry in
//   dut_s/dut_cout DUT response, valid LAT cycles after its stimulus
//   busy           run in progress
//   done           run finished
//   pass           run finished with zero mismatches
//   vec_cnt        vectors compared this run
//   err_cnt        mismatches this run (saturating)
//   first_fail_idx 0-based index of the first mismatching vector
//   first_fail_exp expected {cout,s} of the first mismatching vector
// -----------------------------------------------------------------------------
module adder4b_resp_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] stim_a,
    input  logic [WIDTH-1:0] stim_b,
    input  logic             stim_cin,
    input  logic [WIDTH-1:0] dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH:0]   first_fail_exp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] vec_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;

    logic             start_ok;
    logic             accept;
    logic [WIDTH:0]   exp_now;
    logic             cmp_valid;
    logic [WIDTH:0]   cmp_exp;
    logic             cmp_run;
    logic             mismatch;
    logic             last_cmp;

    // A start is honoured only outside RUN.
    assign start_ok = start && (state_reg != RUN);
    assign accept   = (state_reg == RUN) && stim_valid && (issued_reg < target_reg);

    // Golden result at full WIDTH+1 precision (carry kept).
    assign exp_now  = {1'b0, stim_a} + {1'b0, stim_b} + {{WIDTH{1'b0}}, stim_cin};

    // Alignment line: LAT stages of {valid, exp}. LAT=0 compares in the same cycle.
    if (LAT == 0) begin : g_lat0
        assign cmp_valid = accept;
        assign cmp_exp   = exp_now;
    end else begin : g_dline
        logic [LAT-1:0] dl_v_reg;
        logic [WIDTH:0] dl_e_reg [LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dl_v_reg <= '0;
                for (int i = 0; i < LAT; i++) dl_e_reg[i] <= '0;
            end else if (start_ok) begin
                dl_v_reg <= '0;
            end else begin
                dl_v_reg[0] <= accept;
                dl_e_reg[0] <= exp_now;
                for (int i = 1; i < LAT; i++) begin
                    dl_v_reg[i] <= dl_v_reg[i-1];
                    dl_e_reg[i] <= dl_e_reg[i-1];
                end
            end
        end

        assign cmp_valid = dl_v_reg[LAT-1];
        assign cmp_exp   = dl_e_reg[LAT-1];
    end

    assign cmp_run  = cmp_valid && (state_reg == RUN);
    assign mismatch = cmp_run && ({dut_cout, dut_s} != cmp_exp);
    // This compare completes the run; DONE is entered on the same edge the count updates.
    assign last_cmp = cmp_run && ((vec_cnt_reg + CNT_W'(1)) == target_reg);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) state_next = (num_vec == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_cmp) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
        pass = (state_reg == DONE) && (err_cnt_reg == '0);
    end

    // Run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg  <= '0;
            issued_reg  <= '0;
            vec_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else if (start_ok) begin
            target_reg  <= num_vec;
            issued_reg  <= '0;
            vec_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (accept)  issued_reg  <= issued_reg + CNT_W'(1);
            if (cmp_run) vec_cnt_reg <= vec_cnt_reg + CNT_W'(1);
            if (mismatch && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
    end

    assign vec_cnt = vec_cnt_reg;
    assign err_cnt = err_cnt_reg;

`ifdef ADDER4B_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] ff_idx_reg;
    logic [WIDTH:0]   ff_exp_reg;
    logic             ff_seen_reg;

    // vec_cnt_reg is the 0-based index of the vector being compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_idx_reg  <= '0;
            ff_exp_reg  <= '0;
            ff_seen_reg <= 1'b0;
        end else if (start_ok) begin
            ff_idx_reg  <= '0;
            ff_exp_reg  <= '0;
            ff_seen_reg <= 1'b0;
        end else if (mismatch && !ff_seen_reg) begin
            ff_idx_reg  <= vec_cnt_reg;
            ff_exp_reg  <= cmp_exp;
            ff_seen_reg <= 1'b1;
        end
    end

    assign first_fail_idx = ff_idx_reg;
    assign first_fail_exp = ff_exp_reg;
`else
    assign first_fail_idx = '0;
    assign first_fail_exp = '0;
`endif

endmodule

// File: tb/tb_adder4b_resp_checker.sv
// -----------------------------------------------------------------------------
// Testbench for adder4b_resp_checker: one instance with LAT=0 and one with LAT=2.
// Expected run results are pushed into a queue per instance when a run is
// issued. A monitor pops and compares them whenever that instance's done rises.
// -----------------------------------------------------------------------------
module tb_adder4b_resp_checker;

    localparam int W = 4;
    localparam int C = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // LAT=0 instance
    logic         start0, sv0, cin0;
    logic [C-1:0] num0;
    logic [W-1:0] a0, b0;
    logic [W:0]   resp0;
    logic         busy0, done0, pass0;
    logic [C-1:0] vc0, ec0, ffi0;
    logic [W:0]   ffe0;

    // LAT=2 instance
    logic         start2, sv2, cin2;
    logic [C-1:0] num2;
    logic [W-1:0] a2, b2;
    logic [W:0]   resp2, d1, d2;
    logic         busy2, done2, pass2;
    logic [C-1:0] vc2, ec2, ffi2;
    logic [W:0]   ffe2;

    adder4b_resp_checker #(.WIDTH(W), .CNT_W(C), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .num_vec(num0),
        .stim_valid(sv0), .stim_a(a0), .stim_b(b0), .stim_cin(cin0),
        .dut_s(resp0[W-1:0]), .dut_cout(resp0[W]),
        .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vc0), .err_cnt(ec0),
        .first_fail_idx(ffi0), .first_fail_exp(ffe0)
    );

    adder4b_resp_checker #(.WIDTH(W), .CNT_W(C), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(num2),
        .stim_valid(sv2), .stim_a(a2), .stim_b(b2), .stim_cin(cin2),
        .dut_s(d2[W-1:0]), .dut_cout(d2[W]),
        .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vc2), .err_cnt(ec2),
        .first_fail_idx(ffi2), .first_fail_exp(ffe2)
    );

    // Adder model for the LAT=2 instance: response appears 2 cycles after stimulus.
    always @(posedge clk) begin
        d1 <= resp2;
        d2 <= d1;
    end

    // Vector table for the current run; vm is an xor fault mask (0 = good response).
    logic [W-1:0] va [16];
    logic [W-1:0] vb [16];
    logic         vcin [16];
    logic [W:0]   vm [16];

    typedef struct {
        int vc;
        int ec;
        int pass;
        int ffi;
        int ffe;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Reference model: the first n vectors count; a vector fails if its response was faulted.
    task automatic push_exp(int inst, int n);
        exp_t e;
        bit   seen;
        seen  = 1'b0;
        e.vc  = n;
        e.ec  = 0;
        e.ffi = 0;
        e.ffe = 0;
        for (int i = 0; i < n; i++) begin
            if (vm[i] != '0) begin
                e.ec++;
                if (!seen) begin
                    seen  = 1'b1;
                    e.ffi = i;
                    e.ffe = int'(va[i]) + int'(vb[i]) + int'(vcin[i]);
                end
            end
        end
        e.pass = (e.ec == 0) ? 1 : 0;
        if (inst == 0) q0.push_back(e);
        else           q2.push_back(e);
    endtask

    task automatic start_run(int inst, int n);
        if (inst == 0) begin start0 = 1'b1; num0 = C'(n); end
        else           begin start2 = 1'b1; num2 = C'(n); end
        @(posedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send(int inst, int i);
        logic [W:0] good;
        good = {1'b0, va[i]} + {1'b0, vb[i]} + {{W{1'b0}}, vcin[i]};
        if (inst == 0) begin
            sv0 = 1'b1; a0 = va[i]; b0 = vb[i]; cin0 = vcin[i]; resp0 = good ^ vm[i];
        end else begin
            sv2 = 1'b1; a2 = va[i]; b2 = vb[i]; cin2 = vcin[i]; resp2 = good ^ vm[i];
        end
        @(posedge clk); #1;
        sv0 = 1'b0;
        sv2 = 1'b0;
    endtask

    task automatic do_run(int inst, int n, int nvecs, int gap);
        push_exp(inst, n);
        start_run(inst, n);
        for (int i = 0; i < nvecs; i++) begin
            send(inst, i);
            if (gap != 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(int inst, string name);
        logic d;
        d = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            d = (inst == 0) ? done0 : done2;
            if (d) break;
        end
        chk(name, int'(d), 1);
        @(posedge clk); #1;
    endtask

    task automatic rand_vecs(int nv, int bad_pct);
        for (int i = 0; i < nv; i++) begin
            va[i]   = W'($urandom_range(0, 15));
            vb[i]   = W'($urandom_range(0, 15));
            vcin[i] = 1'($urandom_range(0, 1));
            vm[i]   = ($urandom_range(0, 99) < bad_pct) ? (W+1)'($urandom_range(1, 31)) : '0;
        end
    endtask

    task automatic check_result(int inst);
        exp_t e;
        if (inst == 0) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
                return;
            end
            e = q0.pop_front();
            chk("run0_vec_cnt", int'(vc0), e.vc);
            chk("run0_err_cnt", int'(ec0), e.ec);
            chk("run0_pass", int'(pass0), e.pass);
`ifdef ADDER4B_CHK_FIRST_FAIL_EN
            chk("run0_ff_idx", int'(ffi0), e.ffi);
            chk("run0_ff_exp", int'(ffe0), e.ffe);
`else
            chk("run0_ff_idx_tied", int'(ffi0), 0);
            chk("run0_ff_exp_tied", int'(ffe0), 0);
`endif
        end else begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 1, 0);
                return;
            end
            e = q2.pop_front();
            chk("run2_vec_cnt", int'(vc2), e.vc);
            chk("run2_err_cnt", int'(ec2), e.ec);
            chk("run2_pass", int'(pass2), e.pass);
`ifdef ADDER4B_CHK_FIRST_FAIL_EN
            chk("run2_ff_idx", int'(ffi2), e.ffi);
            chk("run2_ff_exp", int'(ffe2), e.ffe);
`else
            chk("run2_ff_idx_tied", int'(ffi2), 0);
            chk("run2_ff_exp_tied", int'(ffe2), 0);
`endif
        end
    endtask

    // Monitor: each rising done is one finished run to score.
    logic done0_q = 1'b0;
    logic done2_q = 1'b0;
    always @(negedge clk) begin
        if (done0 && !done0_q) check_result(0);
        if (done2 && !done2_q) check_result(2);
        done0_q = done0;
        done2_q = done2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs on both instances
        rst_n  = 1'b0;
        start0 = 1'($urandom_range(0, 1)); sv0 = 1'($urandom_range(0, 1));
        num0   = C'($urandom_range(0, 255));
        a0 = W'($urandom_range(0, 15)); b0 = W'($urandom_range(0, 15));
        cin0 = 1'($urandom_range(0, 1)); resp0 = (W+1)'($urandom_range(0, 31));
        start2 = 1'($urandom_range(0, 1)); sv2 = 1'($urandom_range(0, 1));
        num2   = C'($urandom_range(0, 255));
        a2 = W'($urandom_range(0, 15)); b2 = W'($urandom_range(0, 15));
        cin2 = 1'($urandom_range(0, 1)); resp2 = (W+1)'($urandom_range(0, 31));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_pass0", int'(pass0), 0);
        chk("rst_vec0", int'(vc0), 0);
        chk("rst_err0", int'(ec0), 0);
        chk("rst_ffi0", int'(ffi0), 0);
        chk("rst_ffe0", int'(ffe0), 0);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_done2", int'(done2), 0);
        chk("rst_pass2", int'(pass2), 0);
        chk("rst_vec2", int'(vc2), 0);
        chk("rst_err2", int'(ec2), 0);
        start0 = 1'b0; sv0 = 1'b0; start2 = 1'b0; sv2 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        // Zero target from IDLE: done/pass next cycle, never busy
        push_exp(0, 0);
        chk("zero_busy_before", int'(busy0), 0);
        start_run(0, 0);
        @(negedge clk);
        chk("zero_done", int'(done0), 1);
        chk("zero_pass", int'(pass0), 1);
        chk("zero_busy", int'(busy0), 0);
        @(posedge clk); #1;

        // Good run, LAT=0
        va[0] = 4'h0; vb[0] = 4'h0; vcin[0] = 1'b0;
        va[1] = 4'hF; vb[1] = 4'h0; vcin[1] = 1'b0;
        va[2] = 4'h0; vb[2] = 4'hF; vcin[2] = 1'b1;
        va[3] = 4'hF; vb[3] = 4'h1; vcin[3] = 1'b0;
        va[4] = 4'h1; vb[4] = 4'hF; vcin[4] = 1'b0;
        for (int i = 0; i < 5; i++) vm[i] = '0;
        push_exp(0, 5);
        start_run(0, 5);
        for (int i = 0; i < 4; i++) send(0, i);
        chk("good_not_done_early", int'(done0), 0);
        send(0, 4);
        @(negedge clk);
        chk("good_done_latency", int'(done0), 1);
        chk("good_busy_off", int'(busy0), 0);
        @(posedge clk); #1;

        // Fault injection: dut_s=E on (F,0,0)
        vm[1] = 5'h01;
        do_run(0, 5, 5, 0);
        wait_done(0, "fault_done");
        chk("fault_err_hold", int'(ec0), 1);
        vm[1] = '0;

        // Reset mid-run after 3 compares
        start_run(0, 5);
        for (int i = 0; i < 3; i++) send(0, i);
        chk("midrst_vec_before", int'(vc0), 3);
        chk("midrst_busy_before", int'(busy0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_pass", int'(pass0), 0);
        chk("midrst_vec", int'(vc0), 0);
        chk("midrst_err", int'(ec0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_run(0, 5, 5, 0);
        wait_done(0, "after_rst_done");

        // LAT=2, 4 vectors with 1-cycle gaps, then 2 extra vectors that must be ignored
        va[0] = 4'hF; vb[0] = 4'hF; vcin[0] = 1'b1;
        va[1] = 4'h3; vb[1] = 4'h4; vcin[1] = 1'b0;
        va[2] = 4'h8; vb[2] = 4'h7; vcin[2] = 1'b1;
        va[3] = 4'hA; vb[3] = 4'h5; vcin[3] = 1'b0;
        va[4] = 4'h2; vb[4] = 4'h2; vcin[4] = 1'b0;
        va[5] = 4'h9; vb[5] = 4'h9; vcin[5] = 1'b1;
        for (int i = 0; i < 6; i++) vm[i] = '0;
        vm[4] = 5'h03;
        vm[5] = 5'h10;
        do_run(2, 4, 6, 1);
        wait_done(2, "lat2_done");
        send(2, 4);
        send(2, 5);
        chk("lat2_extra_ignored", int'(vc2), 4);
        chk("lat2_err_hold", int'(ec2), 0);

        // Randomised runs on both instances
        for (int r = 0; r < 8; r++) begin
            int inst, n, nv, gap;
            inst = (r % 2 == 0) ? 0 : 2;
            n    = $urandom_range(1, 8);
            nv   = n + $urandom_range(0, 2);
            gap  = $urandom_range(0, 1);
            rand_vecs(nv, 30);
            do_run(inst, n, nv, gap);
            wait_done(inst, (inst == 0) ? "rand0_done" : "rand2_done");
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
